// File: rtl/nibble_serial_sub.sv
// Multi-cycle WIDTH-bit subtractor: A - B computed as A + ~B + 1, one nibble per clock, LSB first.
// Define SERIAL_ADDSUB_MODE_EN to add an op_add input that selects A + B instead.
module nibble_serial_sub #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDSUB_MODE_EN
    input  logic             op_add,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned N    = WIDTH / 4;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             carry_q, carry_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic             add_mode;
    logic [CntW+1:0]  sh;
    logic [WIDTH-1:0] a_sh, b_sh, nib_mask;
    logic [4:0]       sum5;

`ifdef SERIAL_ADDSUB_MODE_EN
    assign add_mode = op_add;
`else
    assign add_mode = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        c_out_d  = c_out_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        sh       = {cnt_q, 2'b00};
        a_sh     = op_a_q >> sh;
        b_sh     = op_b_q >> sh;
        nib_mask = {{(WIDTH-4){1'b0}}, 4'hF} << sh;
        sum5     = {1'b0, a_sh[3:0]} + {1'b0, b_sh[3:0]} + {4'b0000, carry_q};

        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    op_a_d  = a;
                    op_b_d  = add_mode ? b : ~b;
                    carry_d = ~add_mode;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                diff_d  = (diff_q & ~nib_mask) | ({{(WIDTH-4){1'b0}}, sum5[3:0]} << sh);
                carry_d = sum5[4];
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == CntW'(N - 1)) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    c_out_d = sum5[4];
                    // op_b already holds the true addend, so one overflow rule covers add and sub.
                    ovf_d   = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) &&
                              (diff_d[WIDTH-1] != op_a_q[WIDTH-1]);
                    zero_d  = ~|diff_d;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            op_a_q  <= '0;
            op_b_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign diff  = diff_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;
    assign zero  = zero_q;

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Bench for nibble_serial_sub (WIDTH=32): directed plan vectors plus random operations,
// checked against an arithmetic reference model.
module tb_nibble_serial_sub;

    localparam int unsigned W = 32;
    localparam int unsigned N = W / 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
`ifdef SERIAL_ADDSUB_MODE_EN
    logic         op_add = 1'b0;
`endif
    logic         busy, done, c_out, ovf, zero;
    logic [W-1:0] diff;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] exp_diff;
    logic         exp_c, exp_o, exp_z;

    nibble_serial_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef SERIAL_ADDSUB_MODE_EN
        .op_add(op_add),
`endif
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .c_out (c_out),
        .ovf   (ovf),
        .zero  (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        tests++;
        assert (got === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, expv);
        end
    endtask

    task automatic check_results(input string tag);
        check({tag, "_diff"}, diff, exp_diff);
        check({tag, "_cout"}, {31'b0, c_out}, {31'b0, exp_c});
        check({tag, "_ovf"}, {31'b0, ovf}, {31'b0, exp_o});
        check({tag, "_zero"}, {31'b0, zero}, {31'b0, exp_z});
    endtask

    // Reference: plain wide arithmetic on the operands.
    task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv, input bit add);
        logic [W:0] full;
        longint     r;
        if (add) begin
            full  = {1'b0, av} + {1'b0, bv};
            r     = longint'($signed(av)) + longint'($signed(bv));
            exp_c = full[W];
        end else begin
            full  = {1'b0, av} - {1'b0, bv};
            r     = longint'($signed(av)) - longint'($signed(bv));
            exp_c = (av >= bv);
        end
        exp_diff = full[W-1:0];
        exp_o    = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        exp_z    = (exp_diff == '0);
    endtask

    // Starts at #1 after an edge; ends #1 after the done edge (inside the DONE cycle).
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit add,
                          input bit glitch);
`ifdef SERIAL_ADDSUB_MODE_EN
        model(av, bv, add);
        op_add = add;
`else
        model(av, bv, 1'b0);
`endif
        start = 1'b1;
        a     = av;
        b     = bv;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= N; i++) begin
            if (glitch && i == 3) begin
                start = 1'b1;
                a     = $urandom;
                b     = $urandom;
            end
            check("busy_run", {31'b0, busy}, 32'd1);
            check("done_run", {31'b0, done}, 32'd0);
            @(posedge clk); #1;
            start = 1'b0;
        end
        check("done_pulse", {31'b0, done}, 32'd1);
        check("busy_end", {31'b0, busy}, 32'd0);
        check_results("res");
    endtask

    task automatic idle_check();
        @(posedge clk); #1;
        check("done_single", {31'b0, done}, 32'd0);
        check("busy_idle", {31'b0, busy}, 32'd0);
        check_results("hold");
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        bit           radd;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_diff = '0; exp_c = 1'b0; exp_o = 1'b0; exp_z = 1'b0;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check_results("rst");
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(32'd5, 32'd3, 1'b0, 1'b0);
        check("plan1_diff", diff, 32'h0000_0002);
        check("plan1_cout", {31'b0, c_out}, 32'd1);
        idle_check();
        run_op(32'd3, 32'd5, 1'b0, 1'b0);
        check("plan2_diff", diff, 32'hFFFF_FFFE);
        check("plan2_cout", {31'b0, c_out}, 32'd0);
        idle_check();
        run_op(32'h8000_0000, 32'd1, 1'b0, 1'b0);
        check("plan3_ovf", {31'b0, ovf}, 32'd1);
        idle_check();
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("plan4_diff", diff, 32'h8000_0000);
        idle_check();
        run_op(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0);
        check("plan5_zero", {31'b0, zero}, 32'd1);
        idle_check();
        // Start pulse while busy must be ignored; result reflects the original operands.
        run_op(32'h0000_1000, 32'h0000_0001, 1'b0, 1'b1);
        check("glitch_diff", diff, 32'h0000_0FFF);
        // Start held in the DONE cycle: accepted with no idle gap.
        run_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1'b0);
        idle_check();

        // Reset during RUN aborts with no done pulse.
        start = 1'b1; a = 32'hFFFF_0000; b = 32'h0000_FFFF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        exp_diff = '0; exp_c = 1'b0; exp_o = 1'b0; exp_z = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check_results("abort");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < N + 2; i++) begin
            @(posedge clk); #1;
            check("abort_nodone", {31'b0, done}, 32'd0);
        end
        run_op(32'h10, 32'h01, 1'b0, 1'b0);
        check("post_abort_diff", diff, 32'h0000_000F);
        idle_check();

`ifdef SERIAL_ADDSUB_MODE_EN
        run_op(32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
        check("add1_zero", {31'b0, zero}, 32'd1);
        check("add1_cout", {31'b0, c_out}, 32'd1);
        idle_check();
        run_op(32'h4000_0000, 32'h4000_0000, 1'b1, 1'b0);
        check("add2_ovf", {31'b0, ovf}, 32'd1);
        check("add2_diff", diff, 32'h8000_0000);
        idle_check();
`endif

        for (int k = 0; k < 24; k++) begin
            ra   = $urandom;
            rb   = (k % 5 == 0) ? ra : $urandom;
            radd = 1'($urandom_range(0, 1));
            run_op(ra, rb, radd, k % 4 == 1);
            if ($urandom_range(0, 1) == 1) idle_check();
        end
        idle_check();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
